// File: rtl/fpu_vector_driver.sv
// fpu_vector_driver: power-on / bring-up self-test initiator for the 32-bit
// custom-float FPU adder (1 sign, 10 exponent bias 511, 21 mantissa).
// Walks a fixed table of operand pairs, holds each pair for SETTLE_CYCLES
// clocks, samples the FPU result and scores it against the expected sum.
// Optional build macro: FPU_VEC_STATUS_CHECK_EN -- when defined, a vector also
// requires fpu_status_in == EXACT to pass; otherwise the status is ignored.
module fpu_vector_driver #(
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned NUM_VECTORS   = 5
) (
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] op_a_out,
  output logic [31:0] op_b_out,
  input  logic [31:0] fpu_result_in,
  input  logic [3:0]  fpu_status_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  pass_count,
  output logic [3:0]  fail_count,
  output logic        any_fail,
  output logic [2:0]  first_fail_idx
);

  localparam logic [3:0] STATUS_EXACT = 4'd2;
  localparam logic [2:0] NO_FAIL_IDX  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  settle_cnt;
  logic [2:0]  vec_idx;
  logic [2:0]  vec_idx_nxt;
  logic        launch;
  logic        settle_end;
  logic        last_vec;
  logic        vec_pass;
  logic [31:0] exp_result;

  // Operand A column of the vector table
  function automatic logic [31:0] tbl_op_a(input logic [2:0] idx);
    case (idx)
      3'd0:    tbl_op_a = 32'h4000_0000;  //  2.0
      3'd1:    tbl_op_a = 32'h4010_0000;  //  3.0
      3'd2:    tbl_op_a = 32'h4024_0000;  //  4.5
      3'd3:    tbl_op_a = 32'h4040_0000;  //  8.0
      3'd4:    tbl_op_a = 32'h4038_0000;  //  7.0
      default: tbl_op_a = '0;
    endcase
  endfunction

  // Operand B column of the vector table
  function automatic logic [31:0] tbl_op_b(input logic [2:0] idx);
    case (idx)
      3'd0:    tbl_op_b = 32'h3FE0_0000;  //  1.0
      3'd1:    tbl_op_b = 32'h0000_0000;  //  0.0
      3'd2:    tbl_op_b = 32'h4024_0000;  //  4.5
      3'd3:    tbl_op_b = 32'hC040_0000;  // -8.0
      3'd4:    tbl_op_b = 32'hC010_0000;  // -3.0
      default: tbl_op_b = '0;
    endcase
  endfunction

  // Expected sum column of the vector table
  function automatic logic [31:0] tbl_exp(input logic [2:0] idx);
    case (idx)
      3'd0:    tbl_exp = 32'h4010_0000;  //  3.0
      3'd1:    tbl_exp = 32'h4010_0000;  //  3.0
      3'd2:    tbl_exp = 32'h4044_0000;  //  9.0
      3'd3:    tbl_exp = 32'h0000_0000;  //  0.0
      3'd4:    tbl_exp = 32'h4020_0000;  //  4.0
      default: tbl_exp = '0;
    endcase
  endfunction

  // Decode of run request, settle expiry, last vector and the pass verdict
  always_comb begin
    launch      = start && ((state == IDLE) || (state == DONE));
    settle_end  = (settle_cnt == 8'(SETTLE_CYCLES - 1));
    last_vec    = (vec_idx == 3'(NUM_VECTORS - 1));
    vec_idx_nxt = vec_idx + 3'd1;
    exp_result  = tbl_exp(vec_idx);
`ifdef FPU_VEC_STATUS_CHECK_EN
    vec_pass    = (fpu_result_in == exp_result) && (fpu_status_in == STATUS_EXACT);
`else
    vec_pass    = (fpu_result_in == exp_result);
`endif
  end

`ifndef FPU_VEC_STATUS_CHECK_EN
  logic unused_status;
  assign unused_status = ^{fpu_status_in, STATUS_EXACT};
`endif

  // State register
  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = DRIVE;
      DRIVE:   if (settle_end) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? DONE : DRIVE;
      DONE:    if (launch) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state
  always_comb begin
    busy = (state == DRIVE) || (state == CHECK);
    done = (state == DONE);
  end

  // Operand, index, settle counter and scoreboard registers
  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      op_a_out       <= '0;
      op_b_out       <= '0;
      vec_idx        <= '0;
      settle_cnt     <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      any_fail       <= 1'b0;
      first_fail_idx <= NO_FAIL_IDX;
    end else if (launch) begin
      op_a_out       <= tbl_op_a(3'd0);
      op_b_out       <= tbl_op_b(3'd0);
      vec_idx        <= '0;
      settle_cnt     <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      any_fail       <= 1'b0;
      first_fail_idx <= NO_FAIL_IDX;
    end else begin
      case (state)
        DRIVE: settle_cnt <= settle_cnt + 8'd1;
        CHECK: begin
          if (vec_pass) begin
            pass_count <= pass_count + 4'd1;
          end else begin
            fail_count <= fail_count + 4'd1;
            any_fail   <= 1'b1;
            if (first_fail_idx == NO_FAIL_IDX) first_fail_idx <= vec_idx;
          end
          // Operands stay on the last pair once the table is exhausted
          if (!last_vec) begin
            vec_idx    <= vec_idx_nxt;
            op_a_out   <= tbl_op_a(vec_idx_nxt);
            op_b_out   <= tbl_op_b(vec_idx_nxt);
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_vector_driver.sv
// Self-checking bench for fpu_vector_driver: a lookup-based ideal FPU with
// per-vector corruption and status injection, plus a reference scorer.
module tb_fpu_vector_driver;

  localparam int SETTLE = 10;
  localparam int NVEC   = 5;
  localparam int VLEN   = SETTLE + 1;
  localparam int RUNLEN = NVEC * VLEN;

  logic        clock_100Khz = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a_out, op_b_out, fpu_result_in;
  logic [3:0]  fpu_status_in;
  logic        busy, done, any_fail;
  logic [3:0]  pass_count, fail_count;
  logic [2:0]  first_fail_idx;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] vec_a [NVEC] = '{32'h40000000, 32'h40100000, 32'h40240000, 32'h40400000, 32'h40380000};
  logic [31:0] vec_b [NVEC] = '{32'h3FE00000, 32'h00000000, 32'h40240000, 32'hC0400000, 32'hC0100000};
  logic [31:0] vec_s [NVEC] = '{32'h40100000, 32'h40100000, 32'h40440000, 32'h00000000, 32'h40200000};
  logic [31:0] corrupt_xor [NVEC];
  logic [3:0]  stat [NVEC];

  fpu_vector_driver #(.SETTLE_CYCLES(SETTLE), .NUM_VECTORS(NVEC)) dut (
    .clock_100Khz  (clock_100Khz),
    .reset         (reset),
    .start         (start),
    .op_a_out      (op_a_out),
    .op_b_out      (op_b_out),
    .fpu_result_in (fpu_result_in),
    .fpu_status_in (fpu_status_in),
    .busy          (busy),
    .done          (done),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .any_fail      (any_fail),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  // Ideal combinational FPU: recognises a table pair and returns its sum
  always_comb begin
    fpu_result_in = '0;
    fpu_status_in = 4'd2;
    for (int v = 0; v < NVEC; v++) begin
      if (op_a_out == vec_a[v] && op_b_out == vec_b[v]) begin
        fpu_result_in = vec_s[v] ^ corrupt_xor[v];
        fpu_status_in = stat[v];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit vec_ok(input int v);
`ifdef FPU_VEC_STATUS_CHECK_EN
    return (corrupt_xor[v] == 0) && (stat[v] == 4'd2);
`else
    return (corrupt_xor[v] == 0);
`endif
  endfunction

  task automatic clear_faults();
    for (int v = 0; v < NVEC; v++) begin
      corrupt_xor[v] = '0;
      stat[v] = 4'd2;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op_a"}, op_a_out, 32'h0);
    check({tag, "_op_b"}, op_b_out, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass_count), 32'd0);
    check({tag, "_fail"}, 32'(fail_count), 32'd0);
    check({tag, "_anyf"}, 32'(any_fail), 32'd0);
    check({tag, "_ffi"},  32'(first_fail_idx), 32'd7);
  endtask

  // Pulse start, track operands every cycle, then score the finished run
  task automatic run_and_check(input string tag);
    int n, op_err, exp_pass, exp_ffi;
    exp_pass = 0;
    exp_ffi  = 7;
    for (int v = 0; v < NVEC; v++) begin
      if (vec_ok(v)) exp_pass++;
      else if (exp_ffi == 7) exp_ffi = v;
    end
    @(negedge clock_100Khz);
    start = 1'b1;
    @(posedge clock_100Khz);
    #1 start = 1'b0;
    check({tag, "_busy_at_k"}, 32'(busy), 32'd1);
    check({tag, "_cleared"}, {27'd0, pass_count, done}, 32'd0);
    n = 0;
    op_err = 0;
    while (!done && n < 200) begin
      int idx;
      idx = (n / VLEN > NVEC - 1) ? NVEC - 1 : n / VLEN;
      if (op_a_out !== vec_a[idx] || op_b_out !== vec_b[idx] || busy !== 1'b1) op_err++;
      @(posedge clock_100Khz);
      #1 n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(RUNLEN));
    check({tag, "_op_track"}, 32'(op_err), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass_count), 32'(exp_pass));
    check({tag, "_fail"}, 32'(fail_count), 32'(NVEC - exp_pass));
    check({tag, "_anyf"}, 32'(any_fail), 32'(exp_pass != NVEC));
    check({tag, "_ffi"}, 32'(first_fail_idx), 32'(exp_ffi));
    check({tag, "_op_hold"}, op_a_out, vec_a[NVEC-1]);
  endtask

  initial begin
    int n;
    clear_faults();
    start = 1'b0;
    reset = 1'b1;
    #3 check_reset_values("por");
    @(negedge clock_100Khz);
    reset = 1'b0;
    @(negedge clock_100Khz);

    // Clean run
    run_and_check("clean");

    // Vector 2 corrupted by one LSB
    corrupt_xor[2] = 32'h1;
    run_and_check("v2bad");
    clear_faults();

    // Vectors 1 and 3 corrupted
    corrupt_xor[1] = 32'h0000_0100;
    corrupt_xor[3] = 32'h8000_0000;
    run_and_check("v13bad");
    clear_faults();

    // Wrong status only on vector 0
    stat[0] = 4'd3;
    run_and_check("stat0");
    clear_faults();

    // Reset in the middle of vector 3
    @(negedge clock_100Khz);
    start = 1'b1;
    @(posedge clock_100Khz);
    #1 start = 1'b0;
    repeat (3 * VLEN + 2) @(posedge clock_100Khz);
    #2 reset = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clock_100Khz);
    reset = 1'b0;
    run_and_check("after_rst");

    // Start while busy is ignored; held start in DONE restarts once
    @(negedge clock_100Khz);
    start = 1'b1;
    @(posedge clock_100Khz);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      if (n == 20) start = 1'b1;
      if (n == 21) start = 1'b0;
      @(posedge clock_100Khz);
      #1 n++;
    end
    check("busy_start_latency", 32'(n), 32'(RUNLEN));
    @(negedge clock_100Khz);
    start = 1'b1;
    @(posedge clock_100Khz);
    #1 check("rerun_done_clr", {27'd0, pass_count, done}, 32'd0);
    check("rerun_busy", 32'(busy), 32'd1);
    n = 0;
    repeat (2) begin
      @(posedge clock_100Khz);
      #1 n++;
    end
    start = 1'b0;
    while (!done && n < 200) begin
      @(posedge clock_100Khz);
      #1 n++;
    end
    check("rerun_latency", 32'(n), 32'(RUNLEN));
    check("rerun_pass", 32'(pass_count), 32'(NVEC));

    // Randomised corruption and status patterns
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < NVEC; v++) begin
        corrupt_xor[v] = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h1) : 32'h0;
        stat[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
      end
      run_and_check($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
